// File: rtl/wb_cdb_arbiter_pkg.sv
// Shared definitions for the writeback / common-data-bus arbiter: default widths,
// enable/true constants and the CDB source encoding.
package wb_cdb_arbiter_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ROB_W  = 4;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DEPTH  = 2;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic TRUE    = 1'b1;
    localparam logic FALSE   = 1'b0;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } cdb_src_e;

    function automatic cdb_src_e other_src(input cdb_src_e s);
        return (s == SRC_ALU) ? SRC_LSB : SRC_ALU;
    endfunction

endpackage

// File: rtl/wb_cdb_arbiter_if.sv
// Bus bundle between ALU/LSB producers, the arbiter and the CDB consumers (ROB, LSB).
// Handshake: a producer's item transfers on a rising edge where x_valid && x_ready && rdy;
// x_valid may be held across cycles and the item must stay stable until it transfers.
interface wb_cdb_arbiter_if
    import wb_cdb_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROB_W  = DEF_ROB_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              rdy;
    logic              clr;

    logic              alu_valid;
    logic              alu_ready;
    logic [ROB_W-1:0]  alu_rob;
    logic [DATA_W-1:0] alu_value;
    logic              alu_jump_s;
    logic [ADDR_W-1:0] alu_jump;

    logic              lsb_valid;
    logic              lsb_ready;
    logic [ROB_W-1:0]  lsb_rob;
    logic [DATA_W-1:0] lsb_value;

    logic              cdb_valid;
    cdb_src_e          cdb_src;
    logic [ROB_W-1:0]  cdb_rob;
    logic [DATA_W-1:0] cdb_value;
    logic              cdb_jump_s;
    logic [ADDR_W-1:0] cdb_jump;

    // Round-robin pointer, exported for observability.
    cdb_src_e          prio;

    modport slave (
        input  rdy, clr,
        input  alu_valid, alu_rob, alu_value, alu_jump_s, alu_jump,
        input  lsb_valid, lsb_rob, lsb_value,
        output alu_ready, lsb_ready,
        output cdb_valid, cdb_src, cdb_rob, cdb_value, cdb_jump_s, cdb_jump,
        output prio
    );

    modport master (
        output rdy, clr,
        output alu_valid, alu_rob, alu_value, alu_jump_s, alu_jump,
        output lsb_valid, lsb_rob, lsb_value,
        input  alu_ready, lsb_ready,
        input  cdb_valid, cdb_src, cdb_rob, cdb_value, cdb_jump_s, cdb_jump,
        input  prio
    );

endinterface

// File: rtl/wb_cdb_arbiter_fifo.sv
// Small per-source result buffer: circular FIFO with synchronous flush and async reset.
// A push while full is ignored even if the same edge pops.
module wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign head  = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_cdb_arbiter.sv
// Common-data-bus arbiter: buffers ALU and load results separately and drives one
// registered CDB beat per cycle, alternating sources round-robin when both are pending.
module wb_cdb_arbiter
    import wb_cdb_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROB_W  = DEF_ROB_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    wb_cdb_arbiter_if.slave bus
);
    localparam int ALU_W = ROB_W + DATA_W + 1 + ADDR_W;
    localparam int LSB_W = ROB_W + DATA_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ALU_W-1:0]  alu_head;
    logic [LSB_W-1:0]  lsb_head;
    logic [CNT_W-1:0]  alu_count;
    logic [CNT_W-1:0]  lsb_count;
    logic              alu_empty;
    logic              lsb_empty;
    logic              alu_push;
    logic              lsb_push;
    logic              alu_pop;
    logic              lsb_pop;
    logic              grant_alu;
    logic              grant_lsb;
    logic              active;

    logic [ROB_W-1:0]  alu_h_rob;
    logic [DATA_W-1:0] alu_h_value;
    logic              alu_h_jump_s;
    logic [ADDR_W-1:0] alu_h_jump;
    logic [ROB_W-1:0]  lsb_h_rob;
    logic [DATA_W-1:0] lsb_h_value;

    logic              cdb_valid_q;
    cdb_src_e          cdb_src_q;
    logic [ROB_W-1:0]  cdb_rob_q;
    logic [DATA_W-1:0] cdb_value_q;
    logic              cdb_jump_s_q;
    logic [ADDR_W-1:0] cdb_jump_q;
    cdb_src_e          prio_q;

    // Ready depends only on occupancy and flush, never on what pops this cycle.
    assign bus.alu_ready = (alu_count < CNT_W'(DEPTH)) && !bus.clr;
    assign bus.lsb_ready = (lsb_count < CNT_W'(DEPTH)) && !bus.clr;

    assign active   = bus.rdy && !bus.clr;
    assign alu_push = bus.alu_valid && bus.alu_ready && bus.rdy;
    assign lsb_push = bus.lsb_valid && bus.lsb_ready && bus.rdy;

    assign grant_alu = !alu_empty && (lsb_empty || prio_q == SRC_ALU);
    assign grant_lsb = !lsb_empty && (alu_empty || prio_q == SRC_LSB);
    assign alu_pop   = active && grant_alu;
    assign lsb_pop   = active && grant_lsb;

    assign {alu_h_rob, alu_h_value, alu_h_jump_s, alu_h_jump} = alu_head;
    assign {lsb_h_rob, lsb_h_value} = lsb_head;

    wb_fifo #(.W(ALU_W), .DEPTH(DEPTH)) u_alu_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (alu_push),
        .pop   (alu_pop),
        .flush (bus.clr),
        .din   ({bus.alu_rob, bus.alu_value, bus.alu_jump_s, bus.alu_jump}),
        .head  (alu_head),
        .count (alu_count),
        .empty (alu_empty)
    );

    wb_fifo #(.W(LSB_W), .DEPTH(DEPTH)) u_lsb_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (lsb_push),
        .pop   (lsb_pop),
        .flush (bus.clr),
        .din   ({bus.lsb_rob, bus.lsb_value}),
        .head  (lsb_head),
        .count (lsb_count),
        .empty (lsb_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid_q  <= DISABLE;
            cdb_src_q    <= SRC_ALU;
            cdb_rob_q    <= '0;
            cdb_value_q  <= '0;
            cdb_jump_s_q <= FALSE;
            cdb_jump_q   <= '0;
            prio_q       <= SRC_ALU;
        end else if (bus.clr) begin
            cdb_valid_q <= DISABLE;
            prio_q      <= SRC_ALU;
        end else if (!bus.rdy) begin
            cdb_valid_q <= DISABLE;
        end else if (grant_alu) begin
            cdb_valid_q  <= ENABLE;
            cdb_src_q    <= SRC_ALU;
            cdb_rob_q    <= alu_h_rob;
            cdb_value_q  <= alu_h_value;
            cdb_jump_s_q <= alu_h_jump_s;
            cdb_jump_q   <= alu_h_jump;
            prio_q       <= other_src(SRC_ALU);
        end else if (grant_lsb) begin
            // Loads never redirect fetch, so jump fields are forced clear.
            cdb_valid_q  <= ENABLE;
            cdb_src_q    <= SRC_LSB;
            cdb_rob_q    <= lsb_h_rob;
            cdb_value_q  <= lsb_h_value;
            cdb_jump_s_q <= FALSE;
            cdb_jump_q   <= '0;
            prio_q       <= other_src(SRC_LSB);
        end else begin
            cdb_valid_q <= DISABLE;
        end
    end

    assign bus.cdb_valid  = cdb_valid_q;
    assign bus.cdb_src    = cdb_src_q;
    assign bus.cdb_rob    = cdb_rob_q;
    assign bus.cdb_value  = cdb_value_q;
    assign bus.cdb_jump_s = cdb_jump_s_q;
    assign bus.cdb_jump   = cdb_jump_q;
    assign bus.prio       = prio_q;

endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// Bench for wb_cdb_arbiter: vector table, directed corner sequences and random traffic
// checked against a queue-based reference model.
module tb_wb_cdb_arbiter;
    import wb_cdb_arbiter_pkg::*;

    localparam int DW    = 32;
    localparam int RW    = 4;
    localparam int AW    = 32;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic          src;
        logic [RW-1:0] rob;
        logic [DW-1:0] value;
        logic          js;
        logic [AW-1:0] jmp;
    } beat_t;

    typedef struct {
        logic          rdy, clr, av;
        logic [RW-1:0] arob;
        logic [DW-1:0] aval;
        logic          lv;
        logic [RW-1:0] lrob;
        logic [DW-1:0] lval;
        logic          e_ar, e_lr, e_v, e_src;
        logic [RW-1:0] e_rob;
        logic [DW-1:0] e_val;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_cdb_arbiter_if #(.DATA_W(DW), .ROB_W(RW), .ADDR_W(AW)) bus ();

    wb_cdb_arbiter #(.DATA_W(DW), .ROB_W(RW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per source plus the round-robin owner and CDB image.
    beat_t aq[$];
    beat_t lq[$];
    logic  m_prio;
    logic  m_valid;
    beat_t m_cdb;
    logic  last_ar, last_lr;
    int    beat_cnt;
    logic  saw_lr_low;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic clr,
                         input logic av, input logic [RW-1:0] arob, input logic [DW-1:0] aval,
                         input logic ajs, input logic [AW-1:0] ajmp,
                         input logic lv, input logic [RW-1:0] lrob, input logic [DW-1:0] lval);
        bus.rdy        = rdy;
        bus.clr        = clr;
        bus.alu_valid  = av;
        bus.alu_rob    = arob;
        bus.alu_value  = aval;
        bus.alu_jump_s = ajs;
        bus.alu_jump   = ajmp;
        bus.lsb_valid  = lv;
        bus.lsb_rob    = lrob;
        bus.lsb_value  = lval;
    endtask

    task automatic idle(input logic rdy);
        drive(rdy, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic model_reset();
        aq.delete();
        lq.delete();
        m_prio  = 1'b0;
        m_valid = 1'b0;
        m_cdb   = '0;
    endtask

    // One clock: inputs already driven; called just after a rising edge.
    task automatic cycle();
        logic  m_ar, m_lr, s_rdy, s_clr, a_acc, l_acc;
        beat_t ab, lb;
        @(negedge clk);
        s_rdy = bus.rdy;
        s_clr = bus.clr;
        m_ar  = (aq.size() < DEPTH) && !s_clr;
        m_lr  = (lq.size() < DEPTH) && !s_clr;
        last_ar = bus.alu_ready;
        last_lr = bus.lsb_ready;
        if (!bus.lsb_ready) saw_lr_low = 1'b1;
        chk("alu_ready", bus.alu_ready, m_ar);
        chk("lsb_ready", bus.lsb_ready, m_lr);
        a_acc = bus.alu_valid && m_ar && s_rdy;
        l_acc = bus.lsb_valid && m_lr && s_rdy;
        ab = '{1'b0, bus.alu_rob, bus.alu_value, bus.alu_jump_s, bus.alu_jump};
        lb = '{1'b1, bus.lsb_rob, bus.lsb_value, 1'b0, '0};
        @(posedge clk);
        if (s_clr) begin
            model_reset();
        end else if (!s_rdy) begin
            m_valid = 1'b0;
        end else begin
            if (aq.size() > 0 && (lq.size() == 0 || m_prio == 1'b0)) begin
                m_cdb = aq.pop_front(); m_valid = 1'b1; m_prio = 1'b1;
            end else if (lq.size() > 0) begin
                m_cdb = lq.pop_front(); m_valid = 1'b1; m_prio = 1'b0;
            end else begin
                m_valid = 1'b0;
            end
            if (a_acc) aq.push_back(ab);
            if (l_acc) lq.push_back(lb);
        end
        #1;
        chk("cdb_valid", bus.cdb_valid, m_valid);
        if (m_valid) begin
            beat_cnt++;
            chk("cdb_src", bus.cdb_src, m_cdb.src);
            chk("cdb_rob", bus.cdb_rob, m_cdb.rob);
            chk("cdb_value", bus.cdb_value, m_cdb.value);
            chk("cdb_jump_s", bus.cdb_jump_s, m_cdb.js);
            chk("cdb_jump", bus.cdb_jump, m_cdb.jmp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    // Push na ALU and nl LSB results, holding each until accepted, then drain.
    task automatic stream(input int na, input int nl);
        int ai = 0;
        int li = 0;
        int n  = 0;
        logic av, lv;
        while ((ai < na || li < nl || aq.size() != 0 || lq.size() != 0) && n < 200) begin
            av = (ai < na);
            lv = (li < nl);
            drive(1'b1, 1'b0, av, RW'(ai), DW'('hA00 + ai), 1'b0, '0,
                  lv, RW'(li + 8), DW'('hB00 + li));
            cycle();
            if (av && last_ar) ai++;
            if (lv && last_lr) li++;
            n++;
        end
        chk("stream_done_in_time", (n < 200), 1'b1);
    endtask

    vec_t vecs[11];

    initial begin
        rst = 1'b1;
        idle(1'b1);
        beat_cnt = 0;
        saw_lr_low = 1'b0;
        model_reset();
        do_reset();

        chk("reset_cdb_valid", bus.cdb_valid, 1'b0);
        chk("reset_cdb_src", bus.cdb_src, 1'b0);
        chk("reset_cdb_rob", bus.cdb_rob, '0);
        chk("reset_cdb_value", bus.cdb_value, '0);
        chk("reset_cdb_jump", {bus.cdb_jump_s, bus.cdb_jump}, '0);
        chk("reset_prio", bus.prio, 1'b0);
        chk("reset_ready", {bus.alu_ready, bus.lsb_ready}, 2'b11);

        //             rdy clr av arob aval    lv lrob lval    e_ar e_lr e_v src rob val
        vecs[0]  = '{1, 0, 1, 3, 'h11, 0, 0, 0,      1, 1, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 0,    0, 0, 0,      1, 1, 1, 0, 3, 'h11};
        vecs[2]  = '{1, 0, 1, 1, 'h21, 1, 2, 'h22,   1, 1, 0, 0, 0, 0};
        vecs[3]  = '{1, 0, 1, 4, 'h24, 1, 5, 'h25,   1, 1, 1, 1, 2, 'h22};
        vecs[4]  = '{1, 0, 1, 6, 'h26, 0, 0, 0,      0, 1, 1, 0, 1, 'h21};
        vecs[5]  = '{1, 0, 0, 0, 0,    0, 0, 0,      1, 1, 1, 1, 5, 'h25};
        vecs[6]  = '{0, 0, 1, 7, 'h27, 0, 0, 0,      1, 1, 0, 0, 0, 0};
        vecs[7]  = '{1, 1, 0, 0, 0,    1, 8, 'h28,   0, 0, 0, 0, 0, 0};
        vecs[8]  = '{1, 0, 0, 0, 0,    0, 0, 0,      1, 1, 0, 0, 0, 0};
        vecs[9]  = '{1, 0, 0, 0, 0,    1, 9, 'h29,   1, 1, 0, 0, 0, 0};
        vecs[10] = '{1, 0, 0, 0, 0,    0, 0, 0,      1, 1, 1, 1, 9, 'h29};

        foreach (vecs[i]) begin
            drive(vecs[i].rdy, vecs[i].clr, vecs[i].av, vecs[i].arob, vecs[i].aval, 1'b0, '0,
                  vecs[i].lv, vecs[i].lrob, vecs[i].lval);
            cycle();
            chk("vec_alu_ready", last_ar, vecs[i].e_ar);
            chk("vec_lsb_ready", last_lr, vecs[i].e_lr);
            chk("vec_cdb_valid", bus.cdb_valid, vecs[i].e_v);
            if (vecs[i].e_v) begin
                chk("vec_cdb_src", bus.cdb_src, vecs[i].e_src);
                chk("vec_cdb_rob", bus.cdb_rob, vecs[i].e_rob);
                chk("vec_cdb_value", bus.cdb_value, vecs[i].e_val);
            end
        end

        // Both sources flood: 8 beats, alternating, LSB back-pressured at some point.
        do_reset();
        beat_cnt = 0;
        saw_lr_low = 1'b0;
        stream(4, 4);
        chk("alt_beats", beat_cnt, 8);
        chk("lsb_backpressure_seen", saw_lr_low, 1'b1);

        do_reset();
        beat_cnt = 0;
        stream(6, 4);
        chk("flood_beats", beat_cnt, 10);

        // Flush with entries pending: nothing stale may come out afterwards.
        do_reset();
        repeat (2) begin
            drive(1'b1, 1'b0, 1'b1, 4'hC, 'hC0, 1'b0, '0, 1'b1, 4'hD, 'hD0);
            cycle();
        end
        drive(1'b1, 1'b1, 1'b1, 4'hE, 'hE0, 1'b0, '0, 1'b1, 4'hF, 'hF0);
        cycle();
        chk("clr_cdb_valid", bus.cdb_valid, 1'b0);
        beat_cnt = 0;
        idle(1'b1);
        repeat (4) cycle();
        chk("clr_no_stale_beats", beat_cnt, 0);
        chk("clr_ready_after", {bus.alu_ready, bus.lsb_ready}, 2'b11);

        // Stall: 3 cycles of rdy=0 with pending entries; order resumes afterwards.
        do_reset();
        beat_cnt = 0;
        repeat (2) begin
            drive(1'b1, 1'b0, 1'b1, 4'h1, 'h51, 1'b0, '0, 1'b1, 4'h2, 'h52);
            cycle();
        end
        idle(1'b0);
        repeat (3) begin
            cycle();
            chk("stall_no_beat", bus.cdb_valid, 1'b0);
        end
        idle(1'b1);
        repeat (4) cycle();
        chk("stall_total_beats", beat_cnt, 4);

        // Jump fields: ALU beat carries them, the following LSB beat clears them.
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 4'h1, 'h5, 1'b1, 'h1000, 1'b1, 4'h2, 'h6);
        cycle();
        idle(1'b1);
        cycle();
        chk("jump_alu_src", bus.cdb_src, 1'b0);
        chk("jump_alu_js", bus.cdb_jump_s, 1'b1);
        chk("jump_alu_target", bus.cdb_jump, 'h1000);
        cycle();
        chk("jump_lsb_src", bus.cdb_src, 1'b1);
        chk("jump_lsb_fields", {bus.cdb_jump_s, bus.cdb_jump}, '0);

        // Asynchronous reset between clock edges.
        do_reset();
        repeat (2) begin
            drive(1'b1, 1'b0, 1'b1, 4'h7, 'h77, 1'b0, '0, 1'b1, 4'h8, 'h88);
            cycle();
        end
        chk("pre_async_valid", bus.cdb_valid, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_cdb_valid", bus.cdb_valid, 1'b0);
        chk("async_ready", {bus.alu_ready, bus.lsb_ready}, 2'b11);
        chk("async_prio", bus.prio, 1'b0);
        idle(1'b1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 2) != 0, RW'($urandom), DW'($urandom),
                  1'($urandom), AW'($urandom),
                  $urandom_range(0, 2) != 0, RW'($urandom), DW'($urandom));
            cycle();
        end
        idle(1'b1);
        repeat (6) cycle();
        chk("random_drained", aq.size() + lq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
